test_ppfifo_source: RTL and testbench

Synthetic producer for the read side of a ping-pong FIFO (ppfifo). It presents `ready`/`activate`/`size`/`data`/`strobe` exactly as a real ppfifo read port does, so the user-dout reader (`test_out`) can be exercised without the full `sata_stack`. The pattern is a deterministic word sequence over a programmable total word count. Two internal banks model the ping-pong buffers, with a configurable refill latency.

---
 rtl/test_ppfifo_source_pkg.sv | 28 ++
 rtl/ppfifo_src_bank.sv | 57 +++++
 rtl/test_ppfifo_source.sv | 175 +++++++++++++++++
 tb/tb_test_ppfifo_source.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/test_ppfifo_source_pkg.sv
// Shared types and constants for the synthetic ppfifo read-side producer.
// Pattern LFSR constants are used only when TEST_PPFIFO_SRC_LFSR_EN is defined.
package test_ppfifo_source_pkg;

  typedef enum logic [1:0] {
    TOP_IDLE,
    TOP_RUN,
    TOP_DONE
  } top_state_t;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_ACTIVE
  } bank_state_t;

  localparam int SIZE_W = 24;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/ppfifo_src_bank.sv
// One ping-pong bank: EMPTY -> FILLING (FILL_DELAY cycles) -> FULL -> ACTIVE -> EMPTY.
// Exposes its next state so the top can register ready with no extra cycle of lag.
module ppfifo_src_bank
  import test_ppfifo_source_pkg::*;
#(
  parameter int FILL_DELAY = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fill,
  input  logic [SIZE_W-1:0] i_fill_size,
  input  logic              i_claim,
  input  logic              i_release,
  output logic [1:0]        o_state,
  output logic [1:0]        o_state_nxt,
  output logic [SIZE_W-1:0] o_size
);

  localparam int TW = (FILL_DELAY > 1) ? $clog2(FILL_DELAY) : 1;

  bank_state_t       r_state;
  bank_state_t       w_state_nxt;
  logic [TW-1:0]     r_timer;
  logic [SIZE_W-1:0] r_size;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BANK_EMPTY:   if (i_fill)          w_state_nxt = BANK_FILLING;
      BANK_FILLING: if (r_timer == '0)   w_state_nxt = BANK_FULL;
      BANK_FULL:    if (i_claim)         w_state_nxt = BANK_ACTIVE;
      BANK_ACTIVE:  if (i_release)       w_state_nxt = BANK_EMPTY;
      default:                           w_state_nxt = BANK_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= BANK_EMPTY;
      r_timer <= '0;
      r_size  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == BANK_EMPTY && i_fill) begin
        r_size  <= i_fill_size;
        r_timer <= TW'(FILL_DELAY - 1);
      end else if (r_state == BANK_FILLING && r_timer != '0) begin
        r_timer <= r_timer - TW'(1);
      end
    end
  end

  assign o_state     = r_state;
  assign o_state_nxt = w_state_nxt;
  assign o_size      = r_size;

endmodule

// File: rtl/test_ppfifo_source.sv
// Synthetic ppfifo read port: two banks refilled after FILL_DELAY, ready registered, data fall-through.
// Pattern is an incrementing index, or a Galois LFSR when TEST_PPFIFO_SRC_LFSR_EN is defined.
module test_ppfifo_source
  import test_ppfifo_source_pkg::*;
#(
  parameter int MAX_BURST  = 2048,
  parameter int FILL_DELAY = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [SIZE_W-1:0] i_total_count,
  output logic              o_busy,
  output logic              o_finished,
  output logic              o_protocol_error,
  output logic              o_ready,
  input  logic              i_activate,
  output logic [SIZE_W-1:0] o_size,
  output logic [31:0]       o_data,
  input  logic              i_strobe
);

`ifdef TEST_PPFIFO_SRC_LFSR_EN
  localparam logic [31:0] PAT_SEED = LFSR_SEED;
  function automatic logic [31:0] pat_next(input logic [31:0] s);
    return lfsr_step(s);
  endfunction
`else
  localparam logic [31:0] PAT_SEED = 32'h0;
  function automatic logic [31:0] pat_next(input logic [31:0] s);
    return s + 32'd1;
  endfunction
`endif

  localparam logic [SIZE_W-1:0] MAX_B = SIZE_W'(MAX_BURST);

  top_state_t        r_state;
  top_state_t        w_state_nxt;
  logic [SIZE_W-1:0] r_remaining;
  logic [SIZE_W-1:0] r_strb_cnt;
  logic [31:0]       r_pattern;
  logic              r_ready;
  logic              r_act_d;
  logic              r_active_vld;
  logic              r_active_bank;
  logic              r_first_full;
  logic              r_err;

  logic [1:0]        w_bk_state [2];
  logic [1:0]        w_bk_nxt   [2];
  logic [SIZE_W-1:0] w_bk_size  [2];
  logic [1:0]        w_fill;
  logic [1:0]        w_claim;
  logic [1:0]        w_rel;
  logic [1:0]        w_full;
  logic [1:0]        w_empty;
  logic [1:0]        w_becomes_full;
  logic [1:0]        w_full_nxt;
  logic [1:0]        w_active_nxt;
  logic              w_go;
  logic              w_can_fill;
  logic              w_offer;
  logic              w_act_rise;
  logic              w_accept;
  logic              w_release;
  logic              w_in_burst;
  logic              w_strb_ok;
  logic              w_err;
  logic [SIZE_W-1:0] w_fill_size;
  logic [SIZE_W-1:0] w_cur_size;
  logic [SIZE_W-1:0] w_cur_cnt;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    ppfifo_src_bank #(.FILL_DELAY(FILL_DELAY)) u_bank (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_fill      (w_fill[g]),
      .i_fill_size (w_fill_size),
      .i_claim     (w_claim[g]),
      .i_release   (w_rel[g]),
      .o_state     (w_bk_state[g]),
      .o_state_nxt (w_bk_nxt[g]),
      .o_size      (w_bk_size[g])
    );
    assign w_full[g]         = (w_bk_state[g] == BANK_FULL);
    assign w_empty[g]        = (w_bk_state[g] == BANK_EMPTY);
    assign w_full_nxt[g]     = (w_bk_nxt[g] == BANK_FULL);
    assign w_active_nxt[g]   = (w_bk_nxt[g] == BANK_ACTIVE);
    assign w_becomes_full[g] = w_full_nxt[g] && !w_full[g];
  end

  assign w_go        = (r_state == TOP_IDLE) && i_enable;
  assign w_can_fill  = (r_state == TOP_RUN) && (r_remaining != '0);
  assign w_fill[0]   = w_can_fill && w_empty[0];
  assign w_fill[1]   = w_can_fill && w_empty[1] && !w_empty[0];
  assign w_fill_size = (r_remaining > MAX_B) ? MAX_B : r_remaining;

  // Oldest FULL bank is offered; when only one is FULL it is the one offered.
  assign w_offer    = (w_full[0] && w_full[1]) ? r_first_full : !w_full[0];
  assign w_act_rise = i_activate && !r_act_d;
  assign w_accept   = w_act_rise && r_ready;
  assign w_release  = r_active_vld && !i_activate;
  assign w_in_burst = (r_active_vld && i_activate) || w_accept;
  assign w_cur_size = r_active_vld ? w_bk_size[r_active_bank] : w_bk_size[w_offer];
  assign w_cur_cnt  = w_accept ? '0 : r_strb_cnt;
  assign w_strb_ok  = i_strobe && w_in_burst && (w_cur_cnt < w_cur_size);
  assign w_err      = (i_strobe && !w_strb_ok)
                   || (w_act_rise && !r_ready)
                   || (w_release && (r_strb_cnt < w_cur_size));

  always_comb begin
    w_claim = '0;
    w_rel   = '0;
    w_claim[w_offer]     = w_accept;
    w_rel[r_active_bank] = w_release;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TOP_IDLE: if (i_enable) w_state_nxt = (i_total_count != '0) ? TOP_RUN : TOP_DONE;
      TOP_RUN:  if (r_remaining == '0 && w_empty[0] && w_empty[1]) w_state_nxt = TOP_DONE;
      default:  w_state_nxt = TOP_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= TOP_IDLE;
      r_remaining   <= '0;
      r_strb_cnt    <= '0;
      r_pattern     <= PAT_SEED;
      r_ready       <= 1'b0;
      r_act_d       <= 1'b0;
      r_active_vld  <= 1'b0;
      r_active_bank <= 1'b0;
      r_first_full  <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_act_d <= i_activate;
      r_ready <= (|w_full_nxt) && !(|w_active_nxt);

      if (w_go) r_remaining <= i_total_count;
      else if (|w_fill) r_remaining <= r_remaining - w_fill_size;

      if (w_go) r_pattern <= PAT_SEED;
      else if (w_strb_ok) r_pattern <= pat_next(r_pattern);

      if (w_go) r_err <= 1'b0;
      else if (w_err) r_err <= 1'b1;

      if (w_accept) begin
        r_active_vld  <= 1'b1;
        r_active_bank <= w_offer;
        r_strb_cnt    <= SIZE_W'(w_strb_ok);
      end else begin
        if (w_release) r_active_vld <= 1'b0;
        if (w_strb_ok) r_strb_cnt <= r_strb_cnt + SIZE_W'(1);
      end

      if (w_becomes_full[0] && (w_becomes_full[1] || !w_full_nxt[1])) r_first_full <= 1'b0;
      else if (w_becomes_full[1] && !w_full_nxt[0]) r_first_full <= 1'b1;
    end
  end

  assign o_busy           = (r_state != TOP_IDLE);
  assign o_finished       = (r_state == TOP_DONE);
  assign o_protocol_error = r_err;
  assign o_ready          = r_ready;
  assign o_data           = r_pattern;
  assign o_size           = r_ready      ? w_bk_size[w_offer] :
                            r_active_vld ? w_bk_size[r_active_bank] : '0;

endmodule

// File: tb/tb_test_ppfifo_source.sv
// Directed bench for test_ppfifo_source; expected words are queued at start and popped as read.
module tb_test_ppfifo_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        activate = 1'b0;
  logic        strobe = 1'b0;
  logic [23:0] total_count = '0;
  logic        busy, finished, perr, ready;
  logic [23:0] size;
  logic [31:0] data;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q [$];

`ifdef TEST_PPFIFO_SRC_LFSR_EN
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
  function automatic logic [31:0] model_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction
`else
  localparam logic [31:0] SEED = 32'h0;
  function automatic logic [31:0] model_next(input logic [31:0] s);
    return s + 32'd1;
  endfunction
`endif

  always #5 clk = ~clk;

  test_ppfifo_source dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_enable         (enable),
    .i_total_count    (total_count),
    .o_busy           (busy),
    .o_finished       (finished),
    .o_protocol_error (perr),
    .o_ready          (ready),
    .i_activate       (activate),
    .o_size           (size),
    .o_data           (data),
    .i_strobe         (strobe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int total);
    logic [31:0] m;
    m = SEED;
    for (int i = 0; i < total; i++) begin
      exp_q.push_back(m);
      m = model_next(m);
    end
    @(negedge clk);
    total_count = 24'(total);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
    check(tag, ready, 1);
  endtask

  task automatic read_burst(input int exp_size, input string tag);
    wait_ready({tag, "_ready"});
    check({tag, "_size_offer"}, size, exp_size);
    activate = 1'b1;
    @(negedge clk);
    check({tag, "_ready_fall"}, ready, 0);
    check({tag, "_size_active"}, size, exp_size);
    for (int i = 0; i < exp_size; i++) begin
      check({tag, "_data"}, data, exp_q.pop_front());
      strobe = 1'b1;
      @(negedge clk);
    end
    strobe = 1'b0;
    activate = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_finished(input int bound, input string tag);
    for (int i = 0; i < bound && !finished; i++) begin
      check({tag, "_no_ready"}, ready, 0);
      @(negedge clk);
    end
    check({tag, "_finished"}, finished, 1);
    check({tag, "_busy_hi"}, busy, 1);
    @(negedge clk);
    check({tag, "_finished_pulse"}, finished, 0);
    check({tag, "_busy_lo"}, busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finished"}, finished, 0);
    check({tag, "_perr"}, perr, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_size"}, size, 0);
    check({tag, "_data"}, data, SEED);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single short burst
    start(10);
    read_burst(10, "t1");
    wait_finished(20, "t1");
    check("t1_perr", perr, 0);

    // Multi-bank run: 2048 + 2048 + 904, next bank ready right after release
    start(5000);
    read_burst(2048, "t2a");
    check("t2_gap1", ready, 1);
    read_burst(2048, "t2b");
    check("t2_gap2", ready, 1);
    read_burst(904, "t2c");
    wait_finished(20, "t2");
    check("t2_perr", perr, 0);

    // Strobe without an active bank
    start(4);
    wait_ready("t3_ready");
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    check("t3_strobe_err", perr, 1);
    check("t3_data_hold", data, exp_q[0]);
    read_burst(4, "t3a");
    wait_finished(20, "t3a");

    // New start clears the error; activate rising while not ready flags again
    start(4);
    check("t3_err_cleared", perr, 0);
    check("t3_not_ready", ready, 0);
    activate = 1'b1;
    @(negedge clk);
    activate = 1'b0;
    check("t3_act_err", perr, 1);
    read_burst(4, "t3b");
    wait_finished(20, "t3b");

    // Reset mid-burst at word 37, then a fresh 3-word run
    start(100);
    wait_ready("t4_ready");
    activate = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 37; i++) begin
      check("t4_data", data, exp_q.pop_front());
      strobe = 1'b1;
      @(negedge clk);
    end
    check("t4_word37", data, exp_q[0]);
    strobe = 1'b0;
    activate = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t4_rst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start(3);
    read_burst(3, "t4b");
    wait_finished(20, "t4b");

    // Zero-length run: finished within 2 cycles, never ready
    start(0);
    wait_finished(2, "t5");
    check("t5_perr", perr, 0);

`ifdef TEST_PPFIFO_SRC_LFSR_EN
    // LFSR words: seed, then one step of the seed
    start(2);
    wait_ready("t6_ready");
    activate = 1'b1;
    @(negedge clk);
    check("t6_word0", data, 32'hFFFF_FFFF);
    strobe = 1'b1;
    @(negedge clk);
    check("t6_word1", data, 32'hFFDF_FFFC);
    @(negedge clk);
    strobe = 1'b0;
    activate = 1'b0;
    @(negedge clk);
    wait_finished(20, "t6");
    check("t6_perr", perr, 0);
    exp_q.delete();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
